// File: rtl/rom_rdr_pkg.sv
// Shared types and defaults for the ROM reader controller.
package rom_rdr_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned StateW   = 3;

    typedef enum logic [StateW-1:0] {
        StIdle = 3'd0,
        StAddr = 3'd1,
        StWait = 3'd2,
        StHold = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/rom_reader_ctrl.sv
// Walks a contiguous ROM address window and delivers each word on a valid/ready stream.
// Optional running checksum of transferred words: define ROM_RDR_CHECKSUM_EN.
module rom_reader_ctrl
    import rom_rdr_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_ce,
    output logic              rom_read_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef ROM_RDR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned WaitW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                busy_q, done_q, ce_q, valid_q;
    logic                transfer;

    assign transfer = (state_q == StHold) && out_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wait_d   = wait_q;
        data_d   = data_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = start_addr;
                    remain_d = len;
                    state_d  = (len == '0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                wait_d = '0;
                if (READ_WAIT == 0) begin
                    data_d  = rom_data;
                    last_d  = (remain_q == (ADDR_W+1)'(1));
                    state_d = StHold;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    data_d  = rom_data;
                    last_d  = (remain_q == (ADDR_W+1)'(1));
                    state_d = StHold;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StHold: begin
                if (transfer) begin
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = StDone;
                    end else begin
                        // Address wraps naturally at 2**ADDR_W.
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StAddr;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            wait_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ce_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            last_q   <= last_d;
            busy_q   <= (state_d == StAddr) || (state_d == StWait) || (state_d == StHold);
            done_q   <= (state_d == StDone);
            ce_q     <= (state_d == StAddr) || (state_d == StWait);
            valid_q  <= (state_d == StHold);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rom_address = addr_q;
    assign rom_ce      = ce_q;
    assign rom_read_en = ce_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = valid_q & last_q;

`ifdef ROM_RDR_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && start) begin
            csum_d = '0;
        end else if (transfer) begin
            csum_d = csum_q + data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    // Checksum feature not built.
`endif

endmodule

// File: tb/tb_rom_reader_ctrl.sv
// Self-checking bench: two instances (READ_WAIT=3 and READ_WAIT=0) against a window-level model.
module tb_rom_reader_ctrl;

    localparam int RwA = 3;
    localparam int RwZ = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [8:0] len = 9'd0;
    logic       out_ready = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    logic       start_a, start_z, ready_a, ready_z;
    logic       busy_a, done_a, ce_a, re_a, valid_a, last_a;
    logic       busy_z, done_z, ce_z, re_z, valid_z, last_z;
    logic [7:0] addr_a, romd_a, odata_a, addr_z, romd_z, odata_z;

    assign start_a = start & ~sel;
    assign start_z = start & sel;
    assign ready_a = sel ? 1'b1 : out_ready;
    assign ready_z = sel ? out_ready : 1'b1;

    // ROM model: data = addr ^ 8'h5A when enabled.
    assign romd_a = (ce_a & re_a) ? (addr_a ^ 8'h5A) : 8'h00;
    assign romd_z = (ce_z & re_z) ? (addr_z ^ 8'h5A) : 8'h00;

`ifdef ROM_RDR_CHECKSUM_EN
    logic [7:0] csum_a, csum_z, m_csum;
    assign m_csum = sel ? csum_z : csum_a;
`endif

    rom_reader_ctrl #(.ADDR_W(8), .DATA_W(8), .READ_WAIT(RwA)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_a),
        .start_addr  (start_addr),
        .len         (len),
        .busy        (busy_a),
        .done        (done_a),
        .rom_address (addr_a),
        .rom_ce      (ce_a),
        .rom_read_en (re_a),
        .rom_data    (romd_a),
        .out_data    (odata_a),
        .out_valid   (valid_a),
        .out_ready   (ready_a),
        .out_last    (last_a)
`ifdef ROM_RDR_CHECKSUM_EN
        ,
        .checksum    (csum_a)
`endif
    );

    rom_reader_ctrl #(.ADDR_W(8), .DATA_W(8), .READ_WAIT(RwZ)) dut_z (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_z),
        .start_addr  (start_addr),
        .len         (len),
        .busy        (busy_z),
        .done        (done_z),
        .rom_address (addr_z),
        .rom_ce      (ce_z),
        .rom_read_en (re_z),
        .rom_data    (romd_z),
        .out_data    (odata_z),
        .out_valid   (valid_z),
        .out_ready   (ready_z),
        .out_last    (last_z)
`ifdef ROM_RDR_CHECKSUM_EN
        ,
        .checksum    (csum_z)
`endif
    );

    logic       m_busy, m_done, m_ce, m_re, m_valid, m_last;
    logic [7:0] m_addr, m_data;
    assign m_busy  = sel ? busy_z  : busy_a;
    assign m_done  = sel ? done_z  : done_a;
    assign m_ce    = sel ? ce_z    : ce_a;
    assign m_re    = sel ? re_z    : re_a;
    assign m_valid = sel ? valid_z : valid_a;
    assign m_last  = sel ? last_z  : last_a;
    assign m_addr  = sel ? addr_z  : addr_a;
    assign m_data  = sel ? odata_z : odata_a;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One window: model expects words (sa+i)^5A for i<ln, last on i==ln-1, one done pulse.
    task automatic run(input logic s, input logic [7:0] sa, input logic [8:0] ln,
                       input int stall_word, input int stall_len, input bit rnd, input bit restart);
        int rw, cyc, got, first_valid, done_cnt, bad_proto, bad_stab, bad_busy, stall_left;
        int ce_cnt, bound;
        logic       pv, pt, pl;
        logic [7:0] pd, sum, exp_w, exp_a;
        sel = s;
        rw = s ? RwZ : RwA;
        start_addr = sa;
        len = ln;
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0; got = 0; first_valid = -1; done_cnt = 0; bad_proto = 0; bad_stab = 0;
        bad_busy = 0; stall_left = stall_len; ce_cnt = 0; sum = 8'h00;
        pv = 1'b0; pt = 1'b0; pl = 1'b0; pd = 8'h00;
        bound = 200 + int'(ln) * (rw + 2) * 4 + stall_len;
        while (done_cnt == 0 && cyc < bound) begin
            if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (m_ce !== m_re) bad_proto++;
            if (m_ce === 1'b1 && m_valid === 1'b1) bad_proto++;
            if (m_ce === 1'b1) begin
                ce_cnt++;
                exp_a = sa + 8'(got);
                if (m_addr !== exp_a) bad_proto++;
            end
            if (pv && !pt && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) bad_stab++;
            if (m_done === 1'b1) begin
                done_cnt++;
                if (m_busy !== 1'b0) bad_busy++;
            end else if (m_busy !== 1'b1) begin
                bad_busy++;
            end
            if (restart && cyc == 2) begin
                start = 1'b1;
                start_addr = sa + 8'h40;
            end else begin
                start = 1'b0;
            end
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else if (got == stall_word && m_valid === 1'b1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            pt = (m_valid === 1'b1) && out_ready;
            pv = (m_valid === 1'b1);
            pd = m_data;
            pl = m_last;
            if (pt) begin
                exp_w = (sa + 8'(got)) ^ 8'h5A;
                chk("word", m_data, exp_w);
                chk("last", m_last, got == int'(ln) - 1);
                sum += exp_w;
                got++;
            end
            if (m_done !== 1'b1) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_pulses", done_cnt, 1);
        chk("word_count", got, ln);
        chk("latency", first_valid, (ln == 0) ? -1 : 1 + rw);
        chk("ce_cycles", ce_cnt, int'(ln) * (rw + 1));
        chk("rom_protocol", bad_proto, 0);
        chk("hold_stable", bad_stab, 0);
        chk("busy", bad_busy, 0);
`ifdef ROM_RDR_CHECKSUM_EN
        chk("checksum", m_csum, sum);
`endif
        @(posedge clk);
        #1;
        chk("post_done", {m_done, m_busy, m_valid, m_ce}, 0);
`ifdef ROM_RDR_CHECKSUM_EN
        chk("checksum_hold", m_csum, sum);
`endif
    endtask

    initial begin
        int dseen;
        #1;
        chk("reset_a", {busy_a, done_a, ce_a, re_a, valid_a, last_a, addr_a, odata_a}, 0);
        chk("reset_z", {busy_z, done_z, ce_z, re_z, valid_z, last_z, addr_z, odata_z}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(1'b0, 8'h05, 9'd3, -1, 0, 1'b0, 1'b0);
        run(1'b0, 8'hFE, 9'd4, -1, 0, 1'b0, 1'b0);
        run(1'b0, 8'h33, 9'd0, -1, 0, 1'b0, 1'b0);
        run(1'b1, 8'h44, 9'd0, -1, 0, 1'b0, 1'b0);
        run(1'b0, 8'h20, 9'd6, 1, 5, 1'b0, 1'b0);
        run(1'b1, 8'hFD, 9'd5, 2, 5, 1'b0, 1'b0);
        run(1'b0, 8'h80, 9'd5, -1, 0, 1'b0, 1'b1);

        // Abort in HOLD via asynchronous reset.
        sel = 1'b0;
        start_addr = 8'h10;
        len = 9'd4;
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && valid_a !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("hold_reached", valid_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {busy_a, done_a, ce_a, re_a, valid_a, last_a, addr_a, odata_a}, 0);
        dseen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a === 1'b1) dseen++;
        end
        chk("no_done_on_abort", dseen, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1'b0, 8'h07, 9'd2, -1, 0, 1'b0, 1'b0);

        repeat (4) run(1'b0, 8'($urandom), 9'($urandom_range(1, 12)), -1, 0, 1'b1, 1'b0);
        repeat (4) run(1'b1, 8'($urandom), 9'($urandom_range(1, 12)), -1, 0, 1'b1, 1'b0);

        run(1'b1, 8'h00, 9'd256, -1, 0, 1'b0, 1'b0);
`ifdef ROM_RDR_CHECKSUM_EN
        chk("sweep_checksum_z", m_csum, 8'h80);
`endif
        run(1'b0, 8'h00, 9'd256, -1, 0, 1'b0, 1'b0);
`ifdef ROM_RDR_CHECKSUM_EN
        chk("sweep_checksum_a", m_csum, 8'h80);
`endif
        run(1'b1, 8'h05, 9'd3, -1, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
